// File: rtl/fft_spectrum_buf_if.sv
// FFT output stream, display read port and frame status bundled for fft_spectrum_buf.
// Latency and flow control are set by the attached module; this file only declares the signals.
// hold_clr exists only when SPEC_PEAK_HOLD_EN is defined.
interface fft_spectrum_buf_if #(
    parameter int N_FFT = 256,
    parameter int MAG_W = 17
);
    localparam int AW = $clog2(N_FFT);

    logic             fft_en;
    logic             fft_data_valid;
    logic [31:0]      fft_data;
    logic             frame_lock;
`ifdef SPEC_PEAK_HOLD_EN
    logic             hold_clr;
`endif
    logic [AW-1:0]    rd_addr;
    logic [MAG_W-1:0] rd_data;
    logic             frame_done;
    logic             spec_valid;
    logic [AW-1:0]    peak_bin;
    logic [MAG_W-1:0] peak_mag;

    modport master (
`ifdef SPEC_PEAK_HOLD_EN
        output hold_clr,
`endif
        output fft_en, fft_data_valid, fft_data, frame_lock, rd_addr,
        input  rd_data, frame_done, spec_valid, peak_bin, peak_mag
    );

    modport slave (
`ifdef SPEC_PEAK_HOLD_EN
        input  hold_clr,
`endif
        input  fft_en, fft_data_valid, fft_data, frame_lock, rd_addr,
        output rd_data, frame_done, spec_valid, peak_bin, peak_mag
    );
endinterface

// File: rtl/fft_spectrum_buf.sv
// Bin magnitude (max + min/2) into a bin-addressed spectrum RAM with per-frame peak tracking.
// Latency: sample to RAM write 3 cycles, frame_done one cycle after the last write; rd_data 1 cycle.
// No backpressure: every valid sample is consumed, gaps just leave bubbles. Optional SPEC_PEAK_HOLD_EN adds max-merge (+1 cycle).
module fft_spectrum_buf #(
    parameter int N_FFT   = 256,
    parameter int MAG_W   = 17,
    parameter int SKIP_DC = 1
) (
    input  logic              fft_clk,
    input  logic              rst_n,
    fft_spectrum_buf_if.slave bus
);
    localparam int AW = $clog2(N_FFT);
    localparam logic [AW-1:0] LAST_BIN = AW'(N_FFT - 1);

    typedef enum logic {IDLE, FILL} state_t;

    logic [MAG_W-1:0] mem [N_FFT];

    logic [AW-1:0]    bin;
    logic             acc;
    logic [15:0]      re, im, abs_re, abs_im;
    logic [16:0]      mag_sum;

    logic             s1_vld, s1_lock;
    logic [AW-1:0]    s1_bin;
    logic [15:0]      s1_ar, s1_ai;
    logic             s2_vld, s2_lock;
    logic [AW-1:0]    s2_bin;
    logic [15:0]      s2_mx, s2_mn;
    logic             s3_vld, s3_lock;
    logic [AW-1:0]    s3_bin;
    logic [MAG_W-1:0] s3_mag;

    // write-stage view: S3 directly, or the extra read-modify-write stage
    logic             w_vld, w_lock;
    logic [AW-1:0]    w_bin;
    logic [MAG_W-1:0] w_mag, wr_dat;

    state_t           state, state_nxt;
    logic             drop, drop_nxt;
    logic [AW-1:0]    pk_bin, pk_bin_nxt;
    logic [MAG_W-1:0] pk_mag, pk_mag_nxt;
    logic             start, act_drop, wr_en, last, commit;
    logic             commit_pend;

    logic             frame_done_r, spec_valid_r;
    logic [AW-1:0]    peak_bin_r;
    logic [MAG_W-1:0] peak_mag_r, rd_data_r;

    assign acc     = bus.fft_en & bus.fft_data_valid;
    assign re      = bus.fft_data[15:0];
    assign im      = bus.fft_data[31:16];
    // |-32768| lands on 0x8000, which is exactly 32768 read as unsigned
    assign abs_re  = re[15] ? (~re + 16'd1) : re;
    assign abs_im  = im[15] ? (~im + 16'd1) : im;
    assign mag_sum = {1'b0, s2_mx} + {2'b00, s2_mn[15:1]};

    // bin counter: advances per accepted sample, held at 0 while disabled
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n)                   bin <= '0;
        else if (!bus.fft_en)         bin <= '0;
        else if (bus.fft_data_valid)  bin <= bin + 1'b1;
    end

    // three-stage magnitude pipeline; bin index and lock sample ride along
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0; s1_lock <= 1'b0; s1_bin <= '0; s1_ar <= '0; s1_ai <= '0;
            s2_vld <= 1'b0; s2_lock <= 1'b0; s2_bin <= '0; s2_mx <= '0; s2_mn <= '0;
            s3_vld <= 1'b0; s3_lock <= 1'b0; s3_bin <= '0; s3_mag <= '0;
        end else begin
            s1_vld <= acc;
            s2_vld <= s1_vld & bus.fft_en;
            s3_vld <= s2_vld & bus.fft_en;
            if (acc) begin
                s1_bin  <= bin;
                s1_lock <= bus.frame_lock;
                s1_ar   <= abs_re;
                s1_ai   <= abs_im;
            end
            if (s1_vld) begin
                s2_bin  <= s1_bin;
                s2_lock <= s1_lock;
                s2_mx   <= (s1_ar >= s1_ai) ? s1_ar : s1_ai;
                s2_mn   <= (s1_ar >= s1_ai) ? s1_ai : s1_ar;
            end
            if (s2_vld) begin
                s3_bin  <= s2_bin;
                s3_lock <= s2_lock;
                s3_mag  <= MAG_W'(mag_sum);
            end
        end
    end

`ifdef SPEC_PEAK_HOLD_EN
    logic             s4_vld, s4_lock;
    logic [AW-1:0]    s4_bin;
    logic [MAG_W-1:0] s4_mag, s4_old;
    logic             ovw, ovw_nxt, frame_ovw, frame_ovw_nxt, act_ovw;

    // extra stage carrying the sample while the old RAM word is fetched
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_vld <= 1'b0; s4_lock <= 1'b0; s4_bin <= '0; s4_mag <= '0;
        end else begin
            s4_vld <= s3_vld & bus.fft_en;
            if (s3_vld) begin
                s4_bin  <= s3_bin;
                s4_lock <= s3_lock;
                s4_mag  <= s3_mag;
            end
        end
    end

    // second RAM read port for the merge; consecutive bins never collide
    always_ff @(posedge fft_clk) begin
        if (s3_vld) s4_old <= mem[s3_bin];
    end

    // overwrite request: set by reset or hold_clr, consumed by the next commit
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovw       <= 1'b1;
            frame_ovw <= 1'b1;
        end else begin
            ovw       <= ovw_nxt;
            frame_ovw <= frame_ovw_nxt;
        end
    end

    assign w_vld  = s4_vld;
    assign w_lock = s4_lock;
    assign w_bin  = s4_bin;
    assign w_mag  = s4_mag;
    assign wr_dat = (act_ovw || (s4_mag > s4_old)) ? s4_mag : s4_old;
`else
    assign w_vld  = s3_vld;
    assign w_lock = s3_lock;
    assign w_bin  = s3_bin;
    assign w_mag  = s3_mag;
    assign wr_dat = s3_mag;
`endif

    // frame FSM register plus running peak
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            drop   <= 1'b0;
            pk_bin <= '0;
            pk_mag <= '0;
        end else begin
            state  <= state_nxt;
            drop   <= drop_nxt;
            pk_bin <= pk_bin_nxt;
            pk_mag <= pk_mag_nxt;
        end
    end

    // frame tracking at the write stage, so back-to-back frames hand over cleanly
    always_comb begin
        state_nxt  = state;
        drop_nxt   = drop;
        pk_bin_nxt = pk_bin;
        pk_mag_nxt = pk_mag;
        start      = 1'b0;
        act_drop   = drop;
        wr_en      = 1'b0;
        last       = 1'b0;
        commit     = 1'b0;
`ifdef SPEC_PEAK_HOLD_EN
        act_ovw       = frame_ovw;
        frame_ovw_nxt = frame_ovw;
        ovw_nxt       = ovw;
`endif
        if (!bus.fft_en) begin
            state_nxt = IDLE;
        end else if (w_vld) begin
            start = (w_bin == '0);
            if (start) begin
                act_drop = w_lock;
`ifdef SPEC_PEAK_HOLD_EN
                act_ovw       = ovw;
                frame_ovw_nxt = ovw;
`endif
            end
            if (start || state == FILL) begin
                wr_en  = ~act_drop;
                last   = (w_bin == LAST_BIN);
                commit = last & ~act_drop;
                if (wr_en) begin
                    if (start) begin
                        pk_bin_nxt = '0;
                        pk_mag_nxt = (SKIP_DC != 0) ? '0 : w_mag;
                    end else if (w_mag > pk_mag) begin
                        pk_bin_nxt = w_bin;
                        pk_mag_nxt = w_mag;
                    end
                end
            end
            case (state)
                IDLE: if (start) begin
                    state_nxt = FILL;
                    drop_nxt  = w_lock;
                end
                FILL: if (last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
`ifdef SPEC_PEAK_HOLD_EN
        if (bus.hold_clr)  ovw_nxt = 1'b1;
        else if (commit)   ovw_nxt = 1'b0;
`endif
    end

    // commit one cycle after the last write: pulse and publish the peak
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend  <= 1'b0;
            frame_done_r <= 1'b0;
            spec_valid_r <= 1'b0;
            peak_bin_r   <= '0;
            peak_mag_r   <= '0;
        end else begin
            commit_pend  <= commit;
            frame_done_r <= commit_pend;
            if (commit_pend) begin
                spec_valid_r <= 1'b1;
                peak_bin_r   <= pk_bin;
                peak_mag_r   <= pk_mag;
            end
        end
    end

    // spectrum RAM write port, deliberately not reset
    always_ff @(posedge fft_clk) begin
        if (wr_en) mem[w_bin] <= wr_dat;
    end

    // registered display read; same-address write in this cycle yields the old word
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) rd_data_r <= '0;
        else        rd_data_r <= mem[bus.rd_addr];
    end

    assign bus.rd_data    = rd_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.spec_valid = spec_valid_r;
    assign bus.peak_bin   = peak_bin_r;
    assign bus.peak_mag   = peak_mag_r;
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Randomised frames against a whole-frame reference model; scoreboard monitor checks commits and reads.
// Commit entries carry the expected frame_done cycle; reads are checked one cycle after issue.
// Stimulus never waits on the DUT, so no handshake bound is needed beyond the watchdog.
module tb_fft_spectrum_buf;
    localparam int N_FFT   = 256;
    localparam int MAG_W   = 17;
    localparam int SKIP_DC = 1;
`ifdef SPEC_PEAK_HOLD_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic fft_clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    fft_spectrum_buf_if #(.N_FFT(N_FFT), .MAG_W(MAG_W)) bus ();

    fft_spectrum_buf #(.N_FFT(N_FFT), .MAG_W(MAG_W), .SKIP_DC(SKIP_DC)) dut (
        .fft_clk (fft_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 fft_clk = ~fft_clk;
    always @(posedge fft_clk) cyc <= cyc + 1;

    typedef struct { int cyc; int pbin; int pmag; } commit_t;
    typedef struct { int cyc; int addr; int val; } rd_t;
    commit_t cq[$];
    rd_t     rq[$];
    commit_t ce;
    rd_t     re_item;

    // reference state
    int fr_re [N_FFT];
    int fr_im [N_FFT];
    int ref_ram [N_FFT];
    bit ref_known [N_FFT];
    int ref_pbin = 0, ref_pmag = 0;
    int ref_sv = 0;
    bit ref_ovw = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mag_of(input int r, input int i);
        int a = (r < 0) ? -r : r;
        int b = (i < 0) ? -i : i;
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    function automatic void forget_ram();
        for (int k = 0; k < N_FFT; k++) ref_known[k] = 1'b0;
    endfunction

    function automatic void fill_zero();
        for (int k = 0; k < N_FFT; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
    endfunction

    function automatic void fill_random();
        logic signed [15:0] v;
        for (int k = 0; k < N_FFT; k++) begin
            v = 16'($urandom); fr_re[k] = v;
            v = 16'($urandom); fr_im[k] = v;
            if ($urandom_range(15, 0) == 0) fr_re[k] = -32768;
            if ($urandom_range(15, 0) == 0) fr_im[k] = -32768;
        end
    endfunction

    // whole-frame model: peak by the strict-greater rule, RAM overwrite or max-merge
    task automatic model_commit(input int t_last);
        int pb = 0, pm = 0, m;
        commit_t c;
        for (int k = 0; k < N_FFT; k++) begin
            m = mag_of(fr_re[k], fr_im[k]);
            if (!(SKIP_DC != 0 && k == 0) && m > pm) begin pm = m; pb = k; end
`ifdef SPEC_PEAK_HOLD_EN
            if (ref_ovw) begin ref_ram[k] = m; ref_known[k] = 1'b1; end
            else if (m > ref_ram[k]) ref_ram[k] = m;
`else
            ref_ram[k] = m; ref_known[k] = 1'b1;
`endif
        end
        ref_ovw  = 1'b0;
        ref_pbin = pb;
        ref_pmag = pm;
        ref_sv   = 1;
        c.cyc = t_last + LAT; c.pbin = pb; c.pmag = pm;
        cq.push_back(c);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".peak_bin"},   int'(bus.peak_bin),   ref_pbin);
        check({tag, ".peak_mag"},   int'(bus.peak_mag),   ref_pmag);
        check({tag, ".spec_valid"}, int'(bus.spec_valid), ref_sv);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".rd_data"},    int'(bus.rd_data),    0);
        check({tag, ".frame_done"}, int'(bus.frame_done), 0);
        check({tag, ".spec_valid"}, int'(bus.spec_valid), 0);
        check({tag, ".peak_bin"},   int'(bus.peak_bin),   0);
        check({tag, ".peak_mag"},   int'(bus.peak_mag),   0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge fft_clk);
            bus.fft_data_valid = 1'b0;
        end
    endtask

    task automatic read_addr(input int a);
        rd_t r;
        @(negedge fft_clk);
        bus.fft_data_valid = 1'b0;
        bus.rd_addr = a[$clog2(N_FFT)-1:0];
        if (ref_known[a]) begin
            r.cyc = cyc; r.addr = a; r.val = ref_ram[a];
            rq.push_back(r);
        end
    endtask

    task automatic read_many(input int n);
        for (int i = 0; i < n; i++) read_addr($urandom_range(N_FFT - 1, 0));
    endtask

    // one frame of samples; abort_at >= 0 cuts it short by fft_en drop or reset
    task automatic send_frame(input bit lock, input int gap_max, input int abort_at, input bit by_reset);
        int t_last = 0;
        for (int k = 0; k < N_FFT; k++) begin
            if (k == abort_at) begin
                @(negedge fft_clk);
                bus.fft_data_valid = 1'b0;
                if (by_reset) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero_outputs("reset_mid_fill");
                    ref_pbin = 0; ref_pmag = 0; ref_sv = 0; ref_ovw = 1'b1;
                    repeat (3) @(negedge fft_clk);
                    rst_n = 1'b1;
                end else begin
                    bus.fft_en = 1'b0;
                    repeat (3) @(negedge fft_clk);
                    check_status("abort");
                    bus.fft_en = 1'b1;
                end
                forget_ram();
                return;
            end
            if (gap_max > 0 && $urandom_range(3, 0) == 0) begin
                repeat ($urandom_range(gap_max, 1)) begin
                    @(negedge fft_clk);
                    bus.fft_data_valid = 1'b0;
                end
            end
            @(negedge fft_clk);
            bus.fft_data_valid = 1'b1;
            bus.fft_data       = {fr_im[k][15:0], fr_re[k][15:0]};
            bus.frame_lock     = (k == 0) ? lock : 1'($urandom_range(1, 0));
            t_last             = cyc + 1;
        end
        if (!lock) model_commit(t_last);
    endtask

    // scoreboard monitor: frame_done timing and peaks, plus read data
    always @(negedge fft_clk) begin
        if (rst_n) begin
            if (bus.frame_done) begin
                if (cq.size() == 0) begin
                    check("frame_done_unexpected", int'(bus.frame_done), 0);
                end else begin
                    ce = cq.pop_front();
                    check("frame_done_cycle", cyc, ce.cyc);
                    check("commit.peak_bin", int'(bus.peak_bin), ce.pbin);
                    check("commit.peak_mag", int'(bus.peak_mag), ce.pmag);
                    check("commit.spec_valid", int'(bus.spec_valid), 1);
                end
            end else if (cq.size() > 0 && cyc > cq[0].cyc) begin
                ce = cq.pop_front();
                check("frame_done_missing", int'(bus.frame_done), 1);
            end
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                re_item = rq.pop_front();
                check($sformatf("rd_data@%0d", re_item.addr), int'(bus.rd_data), re_item.val);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.fft_en         = 1'b1;
        bus.fft_data_valid = 1'b0;
        bus.fft_data       = '0;
        bus.frame_lock     = 1'b0;
        bus.rd_addr        = '0;
`ifdef SPEC_PEAK_HOLD_EN
        bus.hold_clr       = 1'b0;
`endif
        forget_ram();
        repeat (3) @(negedge fft_clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // ramp with a full-scale corner at bin 37
        fill_zero();
        for (int k = 0; k < N_FFT; k++) fr_re[k] = k;
        fr_re[37] = -32768; fr_im[37] = -32768;
        send_frame(1'b0, 2, -1, 1'b0);
        idle(8);
        check("ramp.peak_bin", int'(bus.peak_bin), 37);
        check("ramp.peak_mag", int'(bus.peak_mag), 49152);
        read_addr(37); read_addr(5); read_addr(255);
        read_many(5);

        // random frame immediately followed by tie/DC frame
        fill_random();
        send_frame(1'b0, 0, -1, 1'b0);
        fill_zero();
        fr_re[0] = 1000; fr_re[5] = 500; fr_re[9] = 500;
        send_frame(1'b0, 0, -1, 1'b0);
        idle(8);
        check("tie.peak_bin", int'(bus.peak_bin), 5);
        check("tie.peak_mag", int'(bus.peak_mag), 500);
        read_addr(0); read_addr(5); read_addr(9);

        // lock on frame 2 drops it; frame 3 commits
        fill_random();
        send_frame(1'b0, 3, -1, 1'b0);
        idle(8);
        fill_random();
        send_frame(1'b1, 3, -1, 1'b0);
        idle(8);
        check_status("locked");
        read_many(8);
        fill_random();
        send_frame(1'b0, 3, -1, 1'b0);
        idle(8);
        check_status("after_lock");
        read_many(8);

        // fft_en drop at bin 128, then a clean frame
        fill_random();
        send_frame(1'b0, 2, 128, 1'b0);
        fill_random();
        send_frame(1'b0, 2, -1, 1'b0);
        idle(8);
        check_status("after_abort");
        read_many(8);

        // reset at bin 100, then a clean frame
        fill_random();
        send_frame(1'b0, 2, 100, 1'b1);
        idle(2);
        check_status("post_reset");
        fill_random();
        send_frame(1'b0, 1, -1, 1'b0);
        idle(8);
        check_status("after_reset");
        read_many(8);

        // random frames, random locks, sometimes back-to-back
        for (int f = 0; f < 6; f++) begin
            fill_random();
            send_frame(1'($urandom_range(4, 0) == 0), 2, -1, 1'b0);
            if ($urandom_range(1, 0) == 0) begin
                idle(8);
                read_many(4);
            end
        end
        idle(8);
        check_status("random");
        read_many(8);

`ifdef SPEC_PEAK_HOLD_EN
        // peak hold: merge keeps 800, hold_clr lets 200 through
        @(negedge fft_clk); bus.hold_clr = 1'b1;
        @(negedge fft_clk); bus.hold_clr = 1'b0; ref_ovw = 1'b1;
        fill_zero(); fr_re[3] = 800;
        send_frame(1'b0, 1, -1, 1'b0);
        idle(8);
        fill_zero(); fr_re[3] = 200;
        send_frame(1'b0, 1, -1, 1'b0);
        idle(8);
        read_addr(3);
        idle(2);
        bus.rd_addr = 8'd3;
        idle(2);
        check("hold.merge@3", int'(bus.rd_data), 800);
        @(negedge fft_clk); bus.hold_clr = 1'b1;
        @(negedge fft_clk); bus.hold_clr = 1'b0; ref_ovw = 1'b1;
        fill_zero(); fr_re[3] = 200;
        send_frame(1'b0, 1, -1, 1'b0);
        idle(8);
        bus.rd_addr = 8'd3;
        idle(2);
        check("hold.clear@3", int'(bus.rd_data), 200);
        read_many(4);
`endif

        idle(10);
        check("commits_outstanding", cq.size(), 0);
        check("reads_outstanding", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
